// File: rtl/lm_sm_sequencer_pkg.sv
// lm_sm_pkg: shared definitions for the LM/SM sequencer slice.
//   state_t : sequencer state encoding (IDLE / XFER)
//   REG_PC  : architectural index of the program counter (R7)
//   LIST_W  : register-list width, one bit per architectural register
package lm_sm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam logic [2:0] REG_PC = 3'd7;
  localparam int         LIST_W = 8;

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// lm_sm_sequencer_if: request / transfer bundle between the RR/EX stage
// and the LM/SM sequencer.
//   master : pipeline side, drives start/is_lm/reg_list/base_addr/stall_in
//   slave  : sequencer side, drives busy, xfer_* strobes, lm_fwd, done
interface lm_sm_sequencer_if
  import lm_sm_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NREGS  = LIST_W
);

  logic              start;
  logic              is_lm;
  logic [NREGS-1:0]  reg_list;
  logic [ADDR_W-1:0] base_addr;
  logic              stall_in;

  logic              busy;
  logic              xfer_valid;
  logic [2:0]        xfer_reg;
  logic [ADDR_W-1:0] xfer_addr;
  logic              xfer_reg_we;
  logic              xfer_mem_we;
  logic              lm_fwd;
  logic              done;

  modport master (
    output start, is_lm, reg_list, base_addr, stall_in,
    input  busy, xfer_valid, xfer_reg, xfer_addr, xfer_reg_we,
           xfer_mem_we, lm_fwd, done
  );

  modport slave (
    input  start, is_lm, reg_list, base_addr, stall_in,
    output busy, xfer_valid, xfer_reg, xfer_addr, xfer_reg_we,
           xfer_mem_we, lm_fwd, done
  );

endinterface

// File: rtl/lm_sm_sequencer_enc.sv
// lowest_set_enc8: 8-to-3 priority encoder, lowest set index wins.
//   vec : input bit vector
//   idx : index of the lowest set bit (0 when vec is zero)
//   any : vec has at least one bit set
module lowest_set_enc8
  import lm_sm_pkg::*;
(
  input  logic [LIST_W-1:0] vec,
  output logic [2:0]        idx,
  output logic              any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = 3'd0;
    any = |vec;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: expands an LM/SM register list into one register
// transfer per cycle, ascending register order, consecutive addresses.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : lm_sm_sequencer_if.slave (request in, transfer strobes out)
//
//   state | meaning
//   IDLE  | no sequence; pipeline free, operand-A forwarding enabled
//   XFER  | one transfer per unstalled cycle, upstream held, lm_fwd=0
module lm_sm_sequencer
  import lm_sm_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NREGS  = LIST_W
) (
  input  logic               clk,
  input  logic               rst_n,
  lm_sm_sequencer_if.slave   bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NREGS-1:0]  r_pending;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mode;
  logic              r_empty_done;

  logic [2:0]        w_idx;
  logic              w_any;
  logic [NREGS-1:0]  w_rest;
  logic [2:0]        w_rest_idx;
  logic              w_rest_any;
  logic              w_accept;
  logic              w_advance;
  logic              w_last;
  logic              w_unused;

  lowest_set_enc8 u_enc_cur (
    .vec (r_pending),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_rest = r_pending & ~(NREGS'(1) << w_idx);

  // Last transfer: nothing left once the current bit is retired.
  lowest_set_enc8 u_enc_rest (
    .vec (w_rest),
    .idx (w_rest_idx),
    .any (w_rest_any)
  );

  assign w_unused  = ^{w_rest_idx, w_any};
  assign w_accept  = (r_state == ST_IDLE) && bus.start && (|bus.reg_list);
  assign w_advance = (r_state == ST_XFER) && !bus.stall_in;
  assign w_last    = w_advance && !w_rest_any;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_XFER;
      ST_XFER: if (w_last)   w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_addr       <= '0;
      r_mode       <= 1'b0;
      r_empty_done <= 1'b0;
    end else begin
      // An empty list never leaves IDLE; it only owes a done pulse.
      r_empty_done <= (r_state == ST_IDLE) && bus.start && (bus.reg_list == '0);
      if (w_accept) begin
        r_pending <= bus.reg_list;
        r_addr    <= bus.base_addr;
        r_mode    <= bus.is_lm;
      end else if (w_advance) begin
        r_pending <= w_rest;
        r_addr    <= r_addr + 1'b1;
      end
    end
  end

  always_comb begin
    bus.busy        = 1'b0;
    bus.xfer_valid  = 1'b0;
    bus.xfer_reg    = 3'd0;
    bus.xfer_addr   = '0;
    bus.xfer_reg_we = 1'b0;
    bus.xfer_mem_we = 1'b0;
    bus.lm_fwd      = 1'b1;
    bus.done        = r_empty_done;
    if (r_state == ST_XFER) begin
      bus.busy        = 1'b1;
      bus.xfer_valid  = 1'b1;
      bus.xfer_reg    = w_idx;
      bus.xfer_addr   = r_addr;
      bus.xfer_reg_we = r_mode & ~bus.stall_in;
      bus.xfer_mem_we = ~r_mode & ~bus.stall_in;
      bus.lm_fwd      = 1'b0;
      bus.done        = w_last;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  lm_sm_sequencer_if #(.ADDR_W(16)) bus ();

  lm_sm_sequencer #(.ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {busy, valid, reg[2:0], addr[15:0], reg_we, mem_we, lm_fwd, done}
  function automatic logic [24:0] obs_vec();
    return {bus.busy, bus.xfer_valid, bus.xfer_reg, bus.xfer_addr,
            bus.xfer_reg_we, bus.xfer_mem_we, bus.lm_fwd, bus.done};
  endfunction

  localparam logic [24:0] IDLE_VEC = {1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0};

  // Reference: the list becomes an ordered queue of register numbers; each
  // unstalled cycle retires the head at base + position (mod 2^16).
  task automatic run_seq(input bit lm, input logic [7:0] list, input logic [15:0] base,
                         input logic [31:0] stall_pat, input bit chain, input string name);
    int regs[$];
    int j;
    int k;
    bit st;
    logic [24:0] exp_v;
    logic [24:0] got_v;
    for (int i = 0; i < 8; i++) if (list[i]) regs.push_back(i);

    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_lm     = lm;
    bus.reg_list  = list;
    bus.base_addr = base;
    bus.stall_in  = 1'($urandom_range(0, 1));
    #1;
    got_v = obs_vec();
    n_checks++;
    if (got_v !== IDLE_VEC) begin
      n_errors++;
      $display("FAIL %s start_cycle: got %h expected %h", name, got_v, IDLE_VEC);
    end

    if (regs.size() == 0) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.stall_in = 1'($urandom_range(0, 1));
      #1;
      exp_v = {1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      got_v = obs_vec();
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL %s empty_done: got %h expected %h", name, got_v, exp_v);
      end
      @(negedge clk);
      #1;
      got_v = obs_vec();
      n_checks++;
      if (got_v !== IDLE_VEC) begin
        n_errors++;
        $display("FAIL %s empty_after: got %h expected %h", name, got_v, IDLE_VEC);
      end
      return;
    end

    j = 0;
    k = 0;
    while (j < regs.size() && k < 40) begin
      @(negedge clk);
      bus.start     = 1'($urandom_range(0, 1));
      bus.is_lm     = 1'($urandom_range(0, 1));
      bus.reg_list  = 8'($urandom);
      bus.base_addr = 16'($urandom);
      st            = (k < 24) ? stall_pat[k] : 1'b0;
      bus.stall_in  = st;
      #1;
      exp_v = {1'b1, 1'b1, 3'(regs[j]), 16'(base + 16'(j)),
               lm & ~st, ~lm & ~st, 1'b0, (~st) & (j == regs.size() - 1)};
      got_v = obs_vec();
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL %s xfer_cycle%0d: got %h expected %h", name, k, got_v, exp_v);
      end
      if (!st) j++;
      k++;
    end
    n_checks++;
    if (j != regs.size()) begin
      n_errors++;
      $display("FAIL %s cycle_budget: retired %0d expected %0d", name, j, regs.size());
    end

    if (!chain) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.stall_in = 1'($urandom_range(0, 1));
      #1;
      got_v = obs_vec();
      n_checks++;
      if (got_v !== IDLE_VEC) begin
        n_errors++;
        $display("FAIL %s busy_fall: got %h expected %h", name, got_v, IDLE_VEC);
      end
    end
  endtask

  task automatic test_reset();
    logic [24:0] got_v;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_lm     = 1'b0;
    bus.reg_list  = 8'h00;
    bus.base_addr = 16'h0000;
    bus.stall_in  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    got_v = obs_vec();
    n_checks++;
    if (got_v !== IDLE_VEC) begin
      n_errors++;
      $display("FAIL reset_values: got %h expected %h", got_v, IDLE_VEC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lm_basic();
    run_seq(1'b1, 8'b1010_0101, 16'h0100, 32'h0, 1'b0, "lm_basic");
  endtask

  task automatic test_sm_single();
    run_seq(1'b0, 8'h01, 16'h2000, 32'h0, 1'b0, "sm_single");
  endtask

  task automatic test_empty();
    run_seq(1'b1, 8'h00, 16'h1234, 32'h0, 1'b0, "empty_list");
  endtask

  task automatic test_wrap();
    run_seq(1'b1, 8'h03, 16'hFFFF, 32'h0, 1'b0, "addr_wrap");
  endtask

  task automatic test_stall();
    run_seq(1'b0, 8'h06, 16'h0040, 32'h3, 1'b0, "stall_first");
    run_seq(1'b1, 8'h81, 16'h0800, 32'h6, 1'b0, "stall_last");
  endtask

  task automatic test_back_to_back();
    run_seq(1'b1, 8'h90, 16'h0300, 32'h0, 1'b1, "b2b_a");
    run_seq(1'b0, 8'h0C, 16'h0400, 32'h0, 1'b1, "b2b_b");
    run_seq(1'b1, 8'h80, 16'h0500, 32'h0, 1'b0, "b2b_c");
  endtask

  task automatic test_reset_mid();
    logic [24:0] got_v;
    logic [24:0] exp_v;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_lm     = 1'b1;
    bus.reg_list  = 8'hFF;
    bus.base_addr = 16'h0A00;
    bus.stall_in  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    exp_v = {1'b1, 1'b1, 3'd0, 16'h0A00, 1'b1, 1'b0, 1'b0, 1'b0};
    got_v = obs_vec();
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL rst_mid_first: got %h expected %h", got_v, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_v = {1'b1, 1'b1, 3'd1, 16'h0A01, 1'b1, 1'b0, 1'b0, 1'b0};
    got_v = obs_vec();
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL rst_mid_second: got %h expected %h", got_v, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    got_v = obs_vec();
    n_checks++;
    if (got_v !== IDLE_VEC) begin
      n_errors++;
      $display("FAIL rst_mid_after: got %h expected %h", got_v, IDLE_VEC);
    end
    run_seq(1'b0, 8'h24, 16'h0B00, 32'h0, 1'b0, "rst_mid_restart");
  endtask

  task automatic test_random();
    logic [7:0]  list;
    logic [31:0] pat;
    for (int n = 0; n < 25; n++) begin
      list = 8'($urandom);
      if (n % 6 == 5) list = 8'h00;
      pat  = $urandom & $urandom;
      run_seq(1'($urandom_range(0, 1)), list, 16'($urandom), pat,
              1'($urandom_range(0, 1)), "random");
    end
    run_seq(1'b1, 8'h00, 16'h0000, 32'h0, 1'b0, "random_tail");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_lm_basic();
    test_sm_single();
    test_empty();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
